// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the W stage always wins, and buffered
// mul/div results drain into the free slots. Pending destinations go to the hazard unit.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] Result_W,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    output logic        pend_rs,
    output logic        pend_rt,
    output logic        stall_req,
    output logic        RF_WE,
    output logic [4:0]  RF_A3,
    output logic [31:0] RF_WD
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       entReg  [DEPTH];
    logic [31:0]      entData [DEPTH];
    logic [DEPTH-1:0] entLive;
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    waitCnt;

    logic wValid;
    logic empty;
    logic full;
    logic headLive;
    logic doPop;
    logic popLive;
    logic accept;
    logic doPush;
    logic anyRs;
    logic anyRt;

    assign wValid   = RegWriteW && (WriteRegW != 5'd0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign headLive = !empty && entLive[rdPtr];
    // A squashed head still needs a free slot to leave, but never writes.
    assign doPop    = !wValid && !empty;
    assign popLive  = doPop && headLive;
    assign md_ready = !full;
    assign accept   = md_valid && md_ready;
    assign doPush   = accept && (md_reg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            waitCnt <= '0;
            entLive <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entReg[i]  <= 5'd0;
                entData[i] <= 32'd0;
            end
        end else begin
            if (doPop) begin
                rdPtr          <= rdPtr + 1'b1;
                entLive[rdPtr] <= 1'b0;
            end
            if (wValid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entReg[i] == WriteRegW) entLive[i] <= 1'b0;
                end
            end
            // The push lands last so a same-cycle W write cannot squash it.
            if (doPush) begin
                wrPtr          <= wrPtr + 1'b1;
                entReg[wrPtr]  <= md_reg;
                entData[wrPtr] <= md_data;
                entLive[wrPtr] <= 1'b1;
            end
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (!doPush && doPop) count <= count - 1'b1;

            if (empty || doPop)
                waitCnt <= '0;
            else if (headLive && wValid && waitCnt != WW'(MAX_WAIT))
                waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        anyRs = 1'b0;
        anyRt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entLive[i] && entReg[i] == rsD) anyRs = 1'b1;
            if (entLive[i] && entReg[i] == rtD) anyRt = 1'b1;
        end
    end

    assign pend_rs   = anyRs && (rsD != 5'd0);
    assign pend_rt   = anyRt && (rtD != 5'd0);
    assign stall_req = (waitCnt == WW'(MAX_WAIT)) && headLive;

    always_comb begin
        RF_WE = 1'b0;
        RF_A3 = 5'd0;
        RF_WD = 32'd0;
        if (!reset) begin
            if (wValid) begin
                RF_WE = 1'b1;
                RF_A3 = WriteRegW;
                RF_WD = Result_W;
            end else if (popLive) begin
                RF_WE = 1'b1;
                RF_A3 = entReg[rdPtr];
                RF_WD = entData[rdPtr];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: W priority, MD drain, squash,
// full/wrap behaviour and the stall request.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] Result_W;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        pend_rs;
    logic        pend_rt;
    logic        stall_req;
    logic        RF_WE;
    logic [4:0]  RF_A3;
    logic [31:0] RF_WD;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .Result_W(Result_W),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_reg(md_reg), .md_data(md_data),
        .rsD(rsD), .rtD(rtD), .pend_rs(pend_rs), .pend_rt(pend_rt),
        .stall_req(stall_req),
        .RF_WE(RF_WE), .RF_A3(RF_A3), .RF_WD(RF_WD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wport(input logic en, input logic [4:0] r,
                         input logic [31:0] d);
        RegWriteW = en;
        WriteRegW = r;
        Result_W  = d;
    endtask

    task automatic md(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
        md_valid = v;
        md_reg   = r;
        md_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        wport(1'b1, 5'd4, 32'h44);
        md(1'b1, 5'd3, 32'h33);
        rsD = 5'd3;
        rtD = 5'd3;

        // T1: reset dominates everything
        repeat (2) begin
            settle();
            chk("t1_we", RF_WE, 0);
            chk("t1_rdy", md_ready, 1);
            chk("t1_prs", pend_rs, 0);
            chk("t1_prt", pend_rt, 0);
        end
        chk("t1_stall", stall_req, 0);
        chk("t1_a3", RF_A3, 0);
        chk("t1_wd", RF_WD, 0);
        cyc();
        wport(1'b0, 5'd0, 32'd0);
        md(1'b0, 5'd0, 32'd0);
        rsD = 5'd0;
        rtD = 5'd0;
        reset = 1'b0;
        settle();
        chk("idle_we", RF_WE, 0);

        // T2: free port, one MD result, no bypass
        cyc();
        md(1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        chk("t2_nobyp", RF_WE, 0);
        chk("t2_rdy", md_ready, 1);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        settle();
        chk("t2_we", RF_WE, 1);
        chk("t2_a3", RF_A3, 5);
        chk("t2_wd", RF_WD, 32'hDEADBEEF);
        cyc();
        settle();
        chk("t2_empty_we", RF_WE, 0);
        chk("t2_empty_a3", RF_A3, 0);
        chk("t2_empty_wd", RF_WD, 0);

        // T3: W hogs the port, head starves, stall after 4 denials
        cyc();
        wport(1'b1, 5'd8, 32'h88);
        md(1'b1, 5'd9, 32'h99);
        settle();
        chk("t3_wown_a3", RF_A3, 8);
        chk("t3_wown_wd", RF_WD, 32'h88);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        rsD = 5'd9;
        settle();
        chk("t3_pend", pend_rs, 1);
        chk("t3_stall0", stall_req, 0);
        chk("t3_deny_a3", RF_A3, 8);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            settle();
            chk($sformatf("t3_stall_d%0d", k), stall_req, 0);
        end
        cyc();
        settle();
        chk("t3_stall_d4", stall_req, 1);
        cyc();
        settle();
        chk("t3_stall_sat", stall_req, 1);
        wport(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_drain_we", RF_WE, 1);
        chk("t3_drain_a3", RF_A3, 9);
        chk("t3_drain_wd", RF_WD, 32'h99);
        cyc();
        settle();
        chk("t3_after_we", RF_WE, 0);
        chk("t3_after_stall", stall_req, 0);
        chk("t3_after_pend", pend_rs, 0);
        rsD = 5'd0;

        // T4: younger W write to r7 squashes the buffered r7
        cyc();
        md(1'b1, 5'd7, 32'h77);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        wport(1'b1, 5'd7, 32'h700);
        rtD = 5'd7;
        settle();
        chk("t4_pend_pre", pend_rt, 1);
        chk("t4_w_a3", RF_A3, 7);
        chk("t4_w_wd", RF_WD, 32'h700);
        cyc();
        wport(1'b0, 5'd0, 32'd0);
        settle();
        chk("t4_pend_post", pend_rt, 0);
        chk("t4_sq_pop_we", RF_WE, 0);
        chk("t4_sq_stall", stall_req, 0);
        cyc();
        settle();
        chk("t4_sq_gone_we", RF_WE, 0);
        chk("t4_rdy", md_ready, 1);
        rtD = 5'd0;

        // T5: fill, full-with-pop still not ready, then wrap over 6 pushes
        cyc();
        wport(1'b1, 5'd10, 32'hA0);
        md(1'b1, 5'd11, 32'hB1);
        cyc();
        md(1'b1, 5'd12, 32'hB2);
        settle();
        chk("t5_rdy1", md_ready, 1);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        rsD = 5'd11;
        rtD = 5'd12;
        settle();
        chk("t5_full", md_ready, 0);
        chk("t5_prs", pend_rs, 1);
        chk("t5_prt", pend_rt, 1);
        wport(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_popfull_rdy", md_ready, 0);
        chk("t5_pop_a3", RF_A3, 11);
        chk("t5_pop_wd", RF_WD, 32'hB1);
        cyc();
        settle();
        chk("t5_prs_gone", pend_rs, 0);
        for (int i = 0; i < 4; i++) begin
            md(1'b1, 5'(13 + i), 32'hB3 + i);
            #1;
            chk($sformatf("t5_pp_rdy%0d", i), md_ready, 1);
            chk($sformatf("t5_pp_a3_%0d", i), RF_A3, 12 + i);
            chk($sformatf("t5_pp_wd_%0d", i), RF_WD, 32'hB2 + i);
            cyc();
            settle();
        end
        md(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_last_a3", RF_A3, 16);
        chk("t5_last_wd", RF_WD, 32'hB6);
        cyc();
        settle();
        chk("t5_empty_we", RF_WE, 0);
        rsD = 5'd0;
        rtD = 5'd0;

        // T6: a W write to $0 leaves the port free; MD to $0 is dropped
        cyc();
        wport(1'b1, 5'd20, 32'h0);
        md(1'b1, 5'd21, 32'hC1);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        settle();
        chk("t6_deny_a3", RF_A3, 20);
        cyc();
        wport(1'b1, 5'd0, 32'h123);
        settle();
        chk("t6_r0_we", RF_WE, 1);
        chk("t6_r0_a3", RF_A3, 21);
        chk("t6_r0_wd", RF_WD, 32'hC1);
        cyc();
        settle();
        chk("t6_r0_after", RF_WE, 0);
        wport(1'b0, 5'd0, 32'd0);
        md(1'b1, 5'd0, 32'hFF);
        settle();
        chk("t6_z_rdy", md_ready, 1);
        cyc();
        md(1'b0, 5'd0, 32'd0);
        repeat (2) begin
            settle();
            chk("t6_z_we", RF_WE, 0);
            cyc();
        end

        // Reset mid-operation drops the buffered result
        wport(1'b1, 5'd2, 32'h22);
        md(1'b1, 5'd25, 32'hD5);
        rsD = 5'd25;
        cyc();
        md(1'b0, 5'd0, 32'd0);
        settle();
        chk("rst_pend_pre", pend_rs, 1);
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_pend", pend_rs, 0);
        chk("rst_we", RF_WE, 0);
        chk("rst_rdy", md_ready, 1);
        cyc();
        reset = 1'b0;
        wport(1'b0, 5'd0, 32'd0);
        settle();
        chk("rst_after_we", RF_WE, 0);
        chk("rst_after_pend", pend_rs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
